// File: rtl/csr_unit_if.sv
// Execute-stage <-> CSR unit signal bundle. The unit takes the slave side;
// whoever drives instructions/trap events (pipeline or bench) takes master.
interface csr_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            csr_en_i;
    logic [2:0]      csrop_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [4:0]      zimm_i;
    logic            rs1_zero_i;
    logic            instr_retire_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_pc_i;
    logic [XLEN-1:0] trap_cause_i;
    logic            mret_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            illegal_o;
    logic [XLEN-1:0] epc_o;
    logic [XLEN-1:0] trap_vector_o;
    logic            mie_o;

    modport slave (
        input  csr_en_i, csrop_i, csr_addr_i, rs1_data_i, zimm_i, rs1_zero_i,
        input  instr_retire_i, trap_i, trap_pc_i, trap_cause_i, mret_i,
        output csr_rdata_o, illegal_o, epc_o, trap_vector_o, mie_o
    );

    modport master (
        output csr_en_i, csrop_i, csr_addr_i, rs1_data_i, zimm_i, rs1_zero_i,
        output instr_retire_i, trap_i, trap_pc_i, trap_cause_i, mret_i,
        input  csr_rdata_o, illegal_o, epc_o, trap_vector_o, mie_o
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read / decode, clocked
// read-modify-write commit, cycle/instret counters, trap entry and MRET.
module csr_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] MISA        = XLEN'(32'h4000_0100),
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic      clk,
    input  logic      rst,
    csr_unit_if.slave bus
);
    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] MTVEC_RST = MTVEC_RESET & LOW2_MASK;

    logic                 mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0]      mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]      mepc_q, mepc_d, mcause_q, mcause_d;
    logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic            is_imm, op_bad, mapped, wr_req, illegal, csr_we;
    logic [XLEN-1:0] operand, old_val, new_val, mstatus_rd;
    logic [63:0]     cyc_ext, ins_ext, cnt_wr;

    // Counters viewed as 64 bits so high halves above CNT_WIDTH read as zero
    assign cyc_ext    = 64'(mcycle_q);
    assign ins_ext    = 64'(minstret_q);
    assign mstatus_rd = XLEN'({2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

    // Decode: old value, operand, write intent, legality
    always_comb begin
        is_imm  = (bus.csrop_i == 3'd3) || (bus.csrop_i == 3'd4) || (bus.csrop_i == 3'd5);
        op_bad  = (bus.csrop_i[2:1] == 2'b11);
        operand = is_imm ? XLEN'(bus.zimm_i) : bus.rs1_data_i;
        mapped  = 1'b1;
        old_val = '0;
        case (bus.csr_addr_i)
            12'h300:          old_val = mstatus_rd;
            12'h301:          old_val = MISA;
            12'h305:          old_val = mtvec_q;
            12'h340:          old_val = mscratch_q;
            12'h341:          old_val = mepc_q;
            12'h342:          old_val = mcause_q;
            12'hB00, 12'hC00: old_val = cyc_ext[XLEN-1:0];
            12'hB02, 12'hC02: old_val = ins_ext[XLEN-1:0];
            12'hB80, 12'hC80: if (XLEN == 32) old_val = XLEN'(cyc_ext[63:32]); else mapped = 1'b0;
            12'hB82, 12'hC82: if (XLEN == 32) old_val = XLEN'(ins_ext[63:32]); else mapped = 1'b0;
            12'hF14:          old_val = HART_ID;
            default:          mapped = 1'b0;
        endcase
        // Set/clear forms only write when they could change something
        wr_req  = 1'b1;
        new_val = operand;
        case (bus.csrop_i)
            3'd1, 3'd4: begin
                new_val = old_val | operand;
                wr_req  = is_imm ? (bus.zimm_i != 5'd0) : !bus.rs1_zero_i;
            end
            3'd2, 3'd5: begin
                new_val = old_val & ~operand;
                wr_req  = is_imm ? (bus.zimm_i != 5'd0) : !bus.rs1_zero_i;
            end
            default: ;
        endcase
        illegal = bus.csr_en_i &&
                  (!mapped || op_bad || ((bus.csr_addr_i[11:10] == 2'b11) && wr_req));
        // Trap and MRET both outrank a CSR write in the same cycle
        csr_we  = bus.csr_en_i && !illegal && wr_req && !bus.trap_i && !bus.mret_i;
    end

    assign bus.csr_rdata_o   = illegal ? '0 : old_val;
    assign bus.illegal_o     = illegal;
    assign bus.epc_o         = mepc_q;
    assign bus.trap_vector_o = mtvec_q;
    assign bus.mie_o         = mie_q;

    // Next state: counters tick unless written; trap > mret > CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + CNT_WIDTH'(1);
        minstret_d = minstret_q + CNT_WIDTH'(bus.instr_retire_i);
        cnt_wr     = '0;
        if (bus.trap_i) begin
            mepc_d   = bus.trap_pc_i & LOW2_MASK;
            mcause_d = bus.trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (bus.mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            case (bus.csr_addr_i)
                12'h300: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                12'h305: mtvec_d    = new_val & LOW2_MASK;
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = new_val & LOW2_MASK;
                12'h342: mcause_d   = new_val;
                12'hB00: begin
                    cnt_wr            = cyc_ext;
                    cnt_wr[XLEN-1:0]  = new_val;
                    mcycle_d          = cnt_wr[CNT_WIDTH-1:0];
                end
                12'hB80: begin
                    cnt_wr            = cyc_ext;
                    cnt_wr[63:32]     = new_val[31:0];
                    mcycle_d          = cnt_wr[CNT_WIDTH-1:0];
                end
                12'hB02: begin
                    cnt_wr            = ins_ext;
                    cnt_wr[XLEN-1:0]  = new_val;
                    minstret_d        = cnt_wr[CNT_WIDTH-1:0];
                end
                12'hB82: begin
                    cnt_wr            = ins_ext;
                    cnt_wr[63:32]     = new_val[31:0];
                    minstret_d        = cnt_wr[CNT_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios plus random traffic, all checked
// against an architectural model of the M-mode CSRs.
module tb_csr_unit;
    localparam logic [31:0] TVEC_RST = 32'h0000_1003;
    localparam logic [31:0] MISA_V   = 32'h4000_0100;
    localparam logic [31:0] HART_V   = 32'h0000_0005;

    logic clk = 1'b0;
    logic rst = 1'b1;

    csr_unit_if #(.XLEN(32)) bus ();

    csr_unit #(
        .XLEN(32), .CNT_WIDTH(64), .MTVEC_RESET(TVEC_RST),
        .MISA(MISA_V), .HART_ID(HART_V)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Architectural model state
    bit        m_mie, m_mpie;
    bit [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    bit [63:0] m_cyc, m_ins;

    logic [31:0] last_rdata;
    logic        last_ill;

    bit [11:0] addr_tab [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                 12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'hB03};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mtvec = TVEC_RST & ~32'd3;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_read(input bit [11:0] a, output bit ok, output bit [31:0] v);
        ok = 1; v = 0;
        case (a)
            12'h300:          v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301:          v = MISA_V;
            12'h305:          v = m_mtvec;
            12'h340:          v = m_mscratch;
            12'h341:          v = m_mepc;
            12'h342:          v = m_mcause;
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
            12'hF14:          v = HART_V;
            default:          ok = 0;
        endcase
    endtask

    // Expected response to the instruction currently on the inputs
    task automatic model_eval(output bit ill, output bit [31:0] rd,
                              output bit wr_ok, output bit [31:0] nv);
        bit ok, wants, imm;
        bit [31:0] old, opnd;
        int op;
        op  = int'(bus.csrop_i);
        imm = (op >= 3 && op <= 5);
        model_read(bus.csr_addr_i, ok, old);
        opnd  = imm ? {27'b0, bus.zimm_i} : bus.rs1_data_i;
        wants = (op % 3 == 0) || (imm ? (bus.zimm_i != 0) : !bus.rs1_zero_i);
        ill   = bus.csr_en_i && (!ok || op >= 6 || (bus.csr_addr_i[11:10] == 2'b11 && wants));
        case (op % 3)
            0:       nv = opnd;
            1:       nv = old | opnd;
            default: nv = old & ~opnd;
        endcase
        rd    = ill ? 32'd0 : old;
        wr_ok = bus.csr_en_i && !ill && wants;
    endtask

    task automatic model_edge(input bit wr_ok, input bit [31:0] nv);
        bit [63:0] nc, ni;
        if (rst) begin
            model_reset();
            return;
        end
        nc = m_cyc + 1;
        ni = m_ins + 64'(bus.instr_retire_i);
        if (bus.trap_i) begin
            m_mepc = bus.trap_pc_i & ~32'd3; m_mcause = bus.trap_cause_i;
            m_mpie = m_mie; m_mie = 0;
        end else if (bus.mret_i) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr_ok) begin
            case (bus.csr_addr_i)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~32'd3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'hB00: nc = {m_cyc[63:32], nv};
                12'hB80: nc = {nv, m_cyc[31:0]};
                12'hB02: ni = {m_ins[63:32], nv};
                12'hB82: ni = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
    endtask

    task automatic clear_inputs();
        bus.csr_en_i = 0; bus.csrop_i = 0; bus.csr_addr_i = 0; bus.rs1_data_i = 0;
        bus.zimm_i = 0; bus.rs1_zero_i = 0; bus.instr_retire_i = 0; bus.trap_i = 0;
        bus.trap_pc_i = 0; bus.trap_cause_i = 0; bus.mret_i = 0; rst = 0;
    endtask

    // One cycle: check outputs mid-cycle, advance the model at the edge
    task automatic step();
        bit ill, wr_ok;
        bit [31:0] rd, nv;
        @(negedge clk);
        model_eval(ill, rd, wr_ok, nv);
        last_rdata = bus.csr_rdata_o;
        last_ill   = bus.illegal_o;
        if (bus.csr_en_i) begin
            chk("rdata", bus.csr_rdata_o, rd);
            chk("illegal", 32'(bus.illegal_o), 32'(ill));
        end
        chk("epc", bus.epc_o, m_mepc);
        chk("tvec", bus.trap_vector_o, m_mtvec);
        chk("mie", 32'(bus.mie_o), 32'(m_mie));
        @(posedge clk);
        model_edge(wr_ok, nv);
        #1;
        clear_inputs();
    endtask

    task automatic csr(input bit [2:0] op, input bit [11:0] a, input bit [31:0] r,
                       input bit [4:0] z, input bit rz);
        bus.csr_en_i = 1; bus.csrop_i = op; bus.csr_addr_i = a;
        bus.rs1_data_i = r; bus.zimm_i = z; bus.rs1_zero_i = rz;
    endtask

    // CSRRS with rs1=x0: pure read
    task automatic rd_chk(input string tag, input bit [11:0] a, input bit [31:0] exp);
        csr(3'd1, a, 32'hFFFF_FFFF, 5'd0, 1'b1);
        step();
        chk(tag, last_rdata, exp);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1;
        step();
        chk("rst_epc", bus.epc_o, 32'h0);
        chk("rst_tvec", bus.trap_vector_o, 32'h1000);
        chk("rst_mie", 32'(bus.mie_o), 32'h0);
        rd_chk("rst_cyc", 12'hB00, 32'h0);
        rd_chk("misa", 12'h301, MISA_V);
        rd_chk("hartid", 12'hF14, HART_V);

        // mscratch read/write, RS with x0 does not write
        csr(3'd0, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b0); step();
        chk("rw_old", last_rdata, 32'h0);
        rd_chk("rs_x0", 12'h340, 32'hDEAD_BEEF);
        rd_chk("rs_x0_keep", 12'h340, 32'hDEAD_BEEF);

        // immediate clear / zero-immediate set
        csr(3'd0, 12'h340, 32'h0000_F0F0, 5'd0, 1'b0); step();
        csr(3'd5, 12'h340, 32'h0, 5'h10, 1'b0); step();
        chk("rci_old", last_rdata, 32'h0000_F0F0);
        rd_chk("rci_new", 12'h340, 32'h0000_F0E0);
        csr(3'd4, 12'h340, 32'h0, 5'h0, 1'b0); step();
        rd_chk("rsi0", 12'h340, 32'h0000_F0E0);

        // counter half writes and carry/wrap
        csr(3'd0, 12'hB80, 32'h0, 5'd0, 1'b0); step();
        csr(3'd0, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1'b0); step();
        rd_chk("cyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("cyc_lo_wrap", 12'hB00, 32'h0);
        rd_chk("cyc_hi_carry", 12'hB80, 32'h1);
        csr(3'd0, 12'hB80, 32'hFFFF_FFFF, 5'd0, 1'b0); step();
        csr(3'd0, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1'b0); step();
        rd_chk("cyc_full", 12'hB80, 32'hFFFF_FFFF);
        rd_chk("cyc_wrap_hi", 12'hB80, 32'h0);

        // illegal accesses
        csr(3'd0, 12'hC00, 32'h1234, 5'd0, 1'b0); step();
        chk("ill_c00", 32'(last_ill), 32'h1);
        chk("ill_c00_rd", last_rdata, 32'h0);
        csr(3'd0, 12'h7C0, 32'h1234, 5'd0, 1'b0); step();
        chk("ill_7c0", 32'(last_ill), 32'h1);
        csr(3'd6, 12'h340, 32'h1234, 5'd0, 1'b0); step();
        chk("ill_op6", 32'(last_ill), 32'h1);
        csr(3'd1, 12'hC00, 32'h0, 5'd0, 1'b1); step();
        chk("c00_read_ok", 32'(last_ill), 32'h0);
        rd_chk("scratch_kept", 12'h340, 32'h0000_F0E0);

        // trap entry beats a concurrent CSR write, then MRET
        csr(3'd4, 12'h300, 32'h0, 5'd8, 1'b0); step();
        chk("mie_set", 32'(bus.mie_o), 32'h1);
        csr(3'd0, 12'h340, 32'h55, 5'd0, 1'b0);
        bus.trap_i = 1; bus.trap_pc_i = 32'h1002; bus.trap_cause_i = 32'd11;
        step();
        chk("trap_epc", bus.epc_o, 32'h1000);
        chk("trap_mie", 32'(bus.mie_o), 32'h0);
        rd_chk("trap_cause", 12'h342, 32'd11);
        rd_chk("trap_mstatus", 12'h300, 32'h1880);
        rd_chk("trap_scratch", 12'h340, 32'h0000_F0E0);
        bus.mret_i = 1; step();
        chk("mret_mie", 32'(bus.mie_o), 32'h1);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);

        // write to minstret suppresses the retire increment
        csr(3'd0, 12'hB02, 32'd5, 5'd0, 1'b0);
        bus.instr_retire_i = 1; step();
        rd_chk("minstret_wr", 12'hB02, 32'd5);

        // reset mid-sequence
        csr(3'd0, 12'h340, 32'h77, 5'd0, 1'b0);
        bus.instr_retire_i = 1; rst = 1; step();
        rd_chk("rst2_cyc", 12'hB00, 32'h0);
        rd_chk("rst2_ins", 12'hB02, 32'h0);
        rd_chk("rst2_scr", 12'h340, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.csr_en_i       = ($urandom_range(0, 3) != 0);
            bus.csrop_i        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                             : 3'($urandom_range(0, 5));
            bus.csr_addr_i     = addr_tab[$urandom_range(0, 17)];
            bus.rs1_data_i     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            bus.zimm_i         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bus.rs1_zero_i     = ($urandom_range(0, 3) == 0);
            bus.instr_retire_i = ($urandom_range(0, 1) != 0);
            bus.trap_i         = ($urandom_range(0, 11) == 0);
            bus.trap_pc_i      = $urandom;
            bus.trap_cause_i   = $urandom;
            bus.mret_i         = ($urandom_range(0, 11) == 0);
            rst                = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
